// File: rtl/args_align.sv
// args_align: two-stream skew compensator.
//
// Streams A and B carry matching words with an unknown, time-varying
// offset. The leading stream is parked in its own ring FIFO until the
// partner word shows up, then both leave together on out_a/out_b.
//
// Optional feature macro: ARGS_ALIGN_TIMEOUT_EN
//   defined   - a lead word waiting TIMEOUT cycles without a pop sets tout
//               and sends the block to ERR.
//   undefined - no wait counter is built, tout is tied to 0.

module args_align #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     a_vld,
  input  logic [WIDTH_A-1:0]       a_dat,
  input  logic                     b_vld,
  input  logic [WIDTH_B-1:0]       b_dat,
  output logic                     out_vld,
  output logic [WIDTH_A-1:0]       out_a,
  output logic [WIDTH_B-1:0]       out_b,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   skew,
  output logic                     ovf,
  output logic                     tout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    A_LEAD = 2'b01,
    B_LEAD = 2'b10,
    ERR    = 2'b11
  } state_t;

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("args_align: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("args_align: TIMEOUT must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [WIDTH_A-1:0] a_mem [DEPTH];
  logic [WIDTH_B-1:0] b_mem [DEPTH];

  ptr_t   a_wr, a_rd, b_wr, b_rd;
  cnt_t   a_cnt, b_cnt;
  cnt_t   a_cnt_nxt, b_cnt_nxt;
  state_t cur_st, nxt_st;

  // Per-cycle control decoded from counts and live inputs.
  logic               run;
  logic               pair;
  logic               a_pop, b_pop;
  logic               a_push, b_push;
  logic               a_acc, b_acc;
  logic               a_full, b_full;
  logic               ovf_ev;
  logic               to_ev;
  logic [WIDTH_A-1:0] pair_a;
  logic [WIDTH_B-1:0] pair_b;

  // Decode pairing, pushes, pops and overflow for the current cycle.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    run       = 1'b0;
    pair      = 1'b0;
    a_pop     = 1'b0;
    b_pop     = 1'b0;
    a_push    = 1'b0;
    b_push    = 1'b0;
    a_acc     = 1'b0;
    b_acc     = 1'b0;
    ovf_ev    = 1'b0;
    a_full    = (a_cnt == cnt_t'(DEPTH));
    b_full    = (b_cnt == cnt_t'(DEPTH));
    pair_a    = a_dat;
    pair_b    = b_dat;

    // Nothing moves in ERR, and flush throws away the cycle's inputs.
    run  = (cur_st != ERR) && !flush;
    pair = run && ((a_cnt != '0) || a_vld) && ((b_cnt != '0) || b_vld);

    // A buffered head always goes out before the live word behind it.
    a_pop = pair && (a_cnt != '0);
    b_pop = pair && (b_cnt != '0);

    // A live word is stored unless it was paired straight through.
    a_push = run && a_vld && !(pair && (a_cnt == '0));
    b_push = run && b_vld && !(pair && (b_cnt == '0));

    // A full FIFO still takes a word when its head leaves the same cycle.
    a_acc  = a_push && (!a_full || a_pop);
    b_acc  = b_push && (!b_full || b_pop);
    ovf_ev = (a_push && a_full && !a_pop) || (b_push && b_full && !b_pop);

    if (a_cnt != '0) pair_a = a_mem[a_rd];
    if (b_cnt != '0) pair_b = b_mem[b_rd];
  end

  assign a_cnt_nxt = a_cnt + cnt_t'(a_acc) - cnt_t'(a_pop);
  assign b_cnt_nxt = b_cnt + cnt_t'(b_acc) - cnt_t'(b_pop);

  // ---------------------------------------------------------------------
  // Optional lead-word wait limit
  // ---------------------------------------------------------------------
`ifdef ARGS_ALIGN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmr;
  logic          lead;
  logic          tout_r;

  assign lead  = (cur_st == A_LEAD) || (cur_st == B_LEAD);
  // Fires on the cycle whose edge would bring the count up to TIMEOUT.
  assign to_ev = run && lead && !a_pop && !b_pop && (tmr == TW'(TIMEOUT - 1));
  assign tout  = tout_r;

  // Count waiting cycles in a lead state; any pop or leaving the lead restarts it.
  // NOTE: clocked state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr    <= '0;
      tout_r <= 1'b0;
    end else if (flush) begin
      tmr    <= '0;
      tout_r <= 1'b0;
    end else begin
      if (!lead || a_pop || b_pop || to_ev) tmr <= '0;
      else                                  tmr <= tmr + TW'(1);
      if (to_ev) tout_r <= 1'b1;
    end
  end
`else
  // Lead words may wait indefinitely.
  assign to_ev = 1'b0;
  assign tout  = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_st <= IDLE;
    else     cur_st <= nxt_st;
  end

  // Next state tracks the post-update FIFO counts; ERR is sticky until flush.
  always_comb begin
    nxt_st = cur_st;
    if (flush)                  nxt_st = IDLE;
    else if (cur_st == ERR)     nxt_st = ERR;
    else if (ovf_ev || to_ev)   nxt_st = ERR;
    else if (a_cnt_nxt != '0)   nxt_st = A_LEAD;
    else if (b_cnt_nxt != '0)   nxt_st = B_LEAD;
    else                        nxt_st = IDLE;
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and counts
  // ---------------------------------------------------------------------

  // Advance pointers/counts; flush and ERR entry zero both FIFOs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wr  <= '0;
      a_rd  <= '0;
      a_cnt <= '0;
      b_wr  <= '0;
      b_rd  <= '0;
      b_cnt <= '0;
    end else if (flush || ovf_ev || to_ev) begin
      a_wr  <= '0;
      a_rd  <= '0;
      a_cnt <= '0;
      b_wr  <= '0;
      b_rd  <= '0;
      b_cnt <= '0;
    end else begin
      if (a_acc) a_wr <= a_wr + ptr_t'(1);
      if (a_pop) a_rd <= a_rd + ptr_t'(1);
      if (b_acc) b_wr <= b_wr + ptr_t'(1);
      if (b_pop) b_rd <= b_rd + ptr_t'(1);
      a_cnt <= a_cnt_nxt;
      b_cnt <= b_cnt_nxt;
    end
  end

  // Write accepted words into the ring storage.
  // NOTE: the storage arrays carry no reset; the counts alone say which
  // entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (a_acc) a_mem[a_wr] <= a_dat;
    if (b_acc) b_mem[b_wr] <= b_dat;
  end

  // ---------------------------------------------------------------------
  // Registered outputs and sticky flags
  // ---------------------------------------------------------------------

  // Register the aligned pair; data holds while no pair is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_a   <= '0;
      out_b   <= '0;
      ovf     <= 1'b0;
    end else if (flush) begin
      out_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      out_vld <= pair;
      if (pair) begin
        out_a <= pair_a;
        out_b <= pair_b;
      end
      if (ovf_ev) ovf <= 1'b1;
    end
  end

  // Only one FIFO is ever non-empty, so OR gives the occupied depth.
  assign skew  = a_cnt | b_cnt;
  assign state = cur_st;

endmodule

// File: tb/tb_args_align.sv
// tb_args_align: directed bench for args_align with a queue-based model.
// Honors ARGS_ALIGN_TIMEOUT_EN the same way the design does.

module tb_args_align;

  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       a_vld = 1'b0;
  logic [7:0] a_dat = '0;
  logic       b_vld = 1'b0;
  logic [7:0] b_dat = '0;
  logic       out_vld;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [1:0] state;
  logic [4:0] skew;
  logic       ovf;
  logic       tout;

  int vec_cnt = 0;
  int err_cnt = 0;

  args_align #(
    .WIDTH_A (8),
    .WIDTH_B (8),
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .a_vld   (a_vld),
    .a_dat   (a_dat),
    .b_vld   (b_vld),
    .b_dat   (b_dat),
    .out_vld (out_vld),
    .out_a   (out_a),
    .out_b   (out_b),
    .state   (state),
    .skew    (skew),
    .ovf     (ovf),
    .tout    (tout)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model: two word queues, pairing whenever both hold data.
  // ---------------------------------------------------------------------
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       m_vld = 1'b0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic       m_ovf = 1'b0;
  logic       m_tout = 1'b0;
  logic       m_err = 1'b0;
  int         m_wait = 0;
  int         m_state = 0;
  int         m_skew = 0;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_vld = 1'b0; m_a = '0; m_b = '0;
    m_ovf = 1'b0; m_tout = 1'b0; m_err = 1'b0;
    m_wait = 0; m_state = 0; m_skew = 0;
  endtask

  task automatic model_step(input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd,
                            input logic fl);
    logic was_lead, hit_p, hit_o, hit_t;
    int   w;
    if (fl) begin
      qa.delete();
      qb.delete();
      m_vld = 1'b0; m_ovf = 1'b0; m_tout = 1'b0; m_err = 1'b0;
      m_wait = 0; m_state = 0; m_skew = 0;
    end else if (m_err) begin
      m_vld = 1'b0;
    end else begin
      was_lead = (qa.size() != 0) || (qb.size() != 0);
      if (av) qa.push_back(ad);
      if (bv) qb.push_back(bd);
      hit_p = (qa.size() != 0) && (qb.size() != 0);
      if (hit_p) begin
        m_a = qa.pop_front();
        m_b = qb.pop_front();
      end
      m_vld = hit_p;
      hit_o = (qa.size() > DEPTH) || (qb.size() > DEPTH);
      w = (was_lead && !hit_p) ? m_wait + 1 : 0;
      hit_t = 1'b0;
`ifdef ARGS_ALIGN_TIMEOUT_EN
      hit_t = (w >= TO);
`endif
      if (hit_o) m_ovf = 1'b1;
      if (hit_t) m_tout = 1'b1;
      if (hit_o || hit_t) begin
        qa.delete();
        qb.delete();
        m_err = 1'b1;
        w = 0;
      end
      m_wait  = w;
      m_state = m_err ? 3 : (qa.size() != 0) ? 1 : (qb.size() != 0) ? 2 : 0;
      m_skew  = qa.size() + qb.size();
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model consumes the same inputs at the edge.
  task automatic cyc(input logic av, input logic [7:0] ad,
                     input logic bv, input logic [7:0] bd, input logic fl);
    a_vld = av; a_dat = ad; b_vld = bv; b_dat = bd; flush = fl;
    @(posedge clk);
    model_step(av, ad, bv, bd, fl);
    #1;
    a_vld = 1'b0; b_vld = 1'b0; flush = 1'b0;
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_out_vld", 32'(out_vld), 32'(m_vld));
      check("cmp_out_a",   32'(out_a),   32'(m_a));
      check("cmp_out_b",   32'(out_b),   32'(m_b));
      check("cmp_state",   32'(state),   32'(m_state));
      check("cmp_skew",    32'(skew),    32'(m_skew));
      check("cmp_ovf",     32'(ovf),     32'(m_ovf));
      check("cmp_tout",    32'(tout),    32'(m_tout));
    end
  end

  initial begin
    int peak;
    model_reset();
    #1;
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_out_a",   32'(out_a),   0);
    check("rst_state",   32'(state),   0);
    check("rst_skew",    32'(skew),    0);
    check("rst_ovf",     32'(ovf),     0);
    check("rst_tout",    32'(tout),    0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Aligned streams: each pair appears one cycle later, no buffering.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h11 + 8'(i), 1'b1, 8'h21 + 8'(i), 1'b0);
      check("t1_vld",   32'(out_vld), 1);
      check("t1_a",     32'(out_a),   32'h11 + i);
      check("t1_b",     32'(out_b),   32'h21 + i);
      check("t1_state", 32'(state),   0);
    end
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("t1_idle_vld", 32'(out_vld), 0);

    // A leads B by three words.
    peak = 0;
    for (int c = 0; c < 9; c++) begin
      cyc(c <= 4, 8'h01 + 8'(c), (c >= 3) && (c <= 7), 8'hA1 + 8'(c) - 8'd3, 1'b0);
      if (32'(skew) > peak) peak = 32'(skew);
      check("t2_vld", 32'(out_vld), ((c >= 3) && (c <= 7)) ? 1 : 0);
      if (c == 1) check("t2_state_lead", 32'(state), 1);
      if (c == 7) begin
        check("t2_last_a", 32'(out_a), 32'h05);
        check("t2_last_b", 32'(out_b), 32'hA5);
        check("t2_state_idle", 32'(state), 0);
      end
    end
    check("t2_peak_skew", peak, 3);

    // B leads A by two words.
    for (int c = 0; c < 5; c++) begin
      cyc(c >= 2, 8'h50 + 8'(c), c <= 2, 8'h60 + 8'(c), 1'b0);
      if (c == 1) check("t2b_state", 32'(state), 2);
    end

    // Fill the A FIFO, then a simultaneous A/B word at full depth.
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00, 1'b0);
`ifndef ARGS_ALIGN_TIMEOUT_EN
    check("t3_full_skew", 32'(skew), 16);
    cyc(1'b1, 8'h40, 1'b1, 8'hB0, 1'b0);
    check("t3_vld",  32'(out_vld), 1);
    check("t3_a",    32'(out_a),   32'h30);
    check("t3_b",    32'(out_b),   32'hB0);
    check("t3_skew", 32'(skew),    16);
    check("t3_ovf",  32'(ovf),     0);
`else
    check("t3_to_state", 32'(state), 3);
    check("t3_to_tout",  32'(tout),  1);
`endif

    // Seventeen unanswered A words overflow the FIFO.
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00, 1'b0);
`ifndef ARGS_ALIGN_TIMEOUT_EN
    check("t4_ovf", 32'(ovf), 1);
`endif
    check("t4_state", 32'(state), 3);
    check("t4_skew",  32'(skew),  0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 8'hD0 + 8'(i), 1'b0);
      check("t4_err_vld", 32'(out_vld), 0);
    end
    cyc(1'b1, 8'h99, 1'b1, 8'h98, 1'b1);
    check("t4_flush_state", 32'(state),   0);
    check("t4_flush_ovf",   32'(ovf),     0);
    check("t4_flush_vld",   32'(out_vld), 0);

    // One lead word followed by silence.
    cyc(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("t5_wait_state", 32'(state), 1);
    check("t5_wait_tout",  32'(tout),  0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef ARGS_ALIGN_TIMEOUT_EN
    check("t5_state", 32'(state), 3);
    check("t5_tout",  32'(tout),  1);
`else
    check("t5_state", 32'(state), 1);
    check("t5_tout",  32'(tout),  0);
`endif

    // Mid-stream reset with five words buffered.
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h81 + 8'(i), 1'b0, 8'h00, 1'b0);
    check("t6_skew", 32'(skew), 5);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_vld",   32'(out_vld), 0);
    check("t6_rst_a",     32'(out_a),   0);
    check("t6_rst_b",     32'(out_b),   0);
    check("t6_rst_state", 32'(state),   0);
    check("t6_rst_skew",  32'(skew),    0);
    check("t6_rst_ovf",   32'(ovf),     0);
    check("t6_rst_tout",  32'(tout),    0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 8'h5A, 1'b1, 8'h6B, 1'b0);
    check("t6_pair_vld", 32'(out_vld), 1);
    check("t6_pair_a",   32'(out_a),   32'h5A);
    check("t6_pair_b",   32'(out_b),   32'h6B);
    check("t6_state",    32'(state),   0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
